// File: rtl/conv_param_pkg.sv
// Shared types and helpers for the convolution parameter loader.
package conv_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_WM = 3'd1,
        ST_LOAD_BM = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Number of host beats making up one complete parameter load.
    function automatic int unsigned total_beats(input int unsigned units,
                                                input int unsigned words,
                                                input int unsigned filters);
        return units * words + filters;
    endfunction

    // Counter width for a given modulus, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/param_addr_counter.sv
// Wrapping up-counter with enable, synchronous clear and terminal-count flag.
module param_addr_counter #(
    parameter int MODULUS = 2,
    parameter int WIDTH   = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;

    assign o_tc    = (r_count == LAST);
    assign o_count = r_count;

    // Advance on enable, wrapping to zero after the terminal count.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/conv_param_loader.sv
// Streams host words into the conv layer's weight and bias memories and
// holds back the upstream start pulse until the full parameter set is in.
//
// state      | meaning
// IDLE       | no parameters loaded yet
// LOAD_WM    | accepting weight words, unit by unit
// LOAD_BM    | accepting bias words
// FLUSH      | last bias write is on the strobe outputs
// DONE       | parameters committed, start pulses pass through
module conv_param_loader
    import conv_param_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int ADDRESS_BITS      = 15,
    parameter int KERNAL_SIZE       = 5,
    parameter int NUMBER_OF_FILTERS = 6,
    parameter int NUMBER_OF_UNITS   = 3,
    parameter int WM_WORDS          = KERNAL_SIZE * KERNAL_SIZE * NUMBER_OF_FILTERS
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_cfg_start,
    input  logic                       i_host_valid,
    input  logic [DATA_WIDTH-1:0]      i_host_data,
    output logic                       o_host_ready,
    input  logic                       i_start_in,
    input  logic                       i_conv_ready,
    output logic [DATA_WIDTH-1:0]      o_riscv_data,
    output logic [ADDRESS_BITS-1:0]    o_riscv_address,
    output logic [NUMBER_OF_UNITS-1:0] o_wm_enable_write,
    output logic                       o_bm_enable_write,
    output logic                       o_start_from_previous,
    output logic                       o_params_ready
);

    localparam int W_BITS = cnt_width(WM_WORDS);
    localparam int U_BITS = cnt_width(NUMBER_OF_UNITS);
    localparam int B_BITS = cnt_width(NUMBER_OF_FILTERS);

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       r_pending;
    logic [DATA_WIDTH-1:0]      r_data;
    logic [ADDRESS_BITS-1:0]    r_addr;
    logic [NUMBER_OF_UNITS-1:0] r_wm_we;
    logic                       r_bm_we;

    logic                       w_in_wm;
    logic                       w_in_bm;
    logic                       w_accept;
    logic                       w_clr;
    logic                       w_word_en;
    logic                       w_unit_en;
    logic                       w_bias_en;
    logic [W_BITS-1:0]          w_word;
    logic                       w_word_tc;
    logic [U_BITS-1:0]          w_unit;
    logic                       w_unit_tc;
    logic [B_BITS-1:0]          w_bias;
    logic                       w_bias_tc;
    logic [NUMBER_OF_UNITS-1:0] w_unit_onehot;

    assign w_in_wm   = (r_state == ST_LOAD_WM);
    assign w_in_bm   = (r_state == ST_LOAD_BM);
    assign w_accept  = i_host_valid && (w_in_wm || w_in_bm);
    // Counters normally wrap back to zero on their own; clearing outside the
    // load states guarantees a reload always starts at unit 0, word 0.
    assign w_clr     = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_word_en = w_accept && w_in_wm;
    assign w_unit_en = w_word_en && w_word_tc;
    assign w_bias_en = w_accept && w_in_bm;

    assign w_unit_onehot = NUMBER_OF_UNITS'(1) << w_unit;

    param_addr_counter #(.MODULUS(WM_WORDS), .WIDTH(W_BITS)) u_word_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_clr),
        .i_en    (w_word_en),
        .o_count (w_word),
        .o_tc    (w_word_tc)
    );

    param_addr_counter #(.MODULUS(NUMBER_OF_UNITS), .WIDTH(U_BITS)) u_unit_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_clr),
        .i_en    (w_unit_en),
        .o_count (w_unit),
        .o_tc    (w_unit_tc)
    );

    param_addr_counter #(.MODULUS(NUMBER_OF_FILTERS), .WIDTH(B_BITS)) u_bias_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_clr),
        .i_en    (w_bias_en),
        .o_count (w_bias),
        .o_tc    (w_bias_tc)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the state-derived handshake and start outputs.
    always_comb begin
        w_state_next          = r_state;
        o_host_ready          = 1'b0;
        o_params_ready        = 1'b0;
        o_start_from_previous = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cfg_start) begin
                    w_state_next = ST_LOAD_WM;
                end
            end
            ST_LOAD_WM: begin
                o_host_ready = 1'b1;
                if (w_unit_en && w_unit_tc) begin
                    w_state_next = ST_LOAD_BM;
                end
            end
            ST_LOAD_BM: begin
                o_host_ready = 1'b1;
                if (w_bias_en && w_bias_tc) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                o_params_ready        = 1'b1;
                o_start_from_previous = i_start_in || r_pending;
                if (i_cfg_start && i_conv_ready) begin
                    w_state_next = ST_LOAD_WM;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Remember an early start; it is released (and dropped) in DONE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_pending <= 1'b0;
        end else if (i_start_in) begin
            r_pending <= 1'b1;
        end
    end

    // Registered write port: strobes pulse per beat, data/address hold otherwise.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wm_we <= '0;
            r_bm_we <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
        end else begin
            r_wm_we <= w_word_en ? w_unit_onehot : '0;
            r_bm_we <= w_bias_en;
            if (w_accept) begin
                r_data <= i_host_data;
                r_addr <= w_in_wm ? ADDRESS_BITS'(w_word) : ADDRESS_BITS'(w_bias);
            end
        end
    end

    assign o_riscv_data      = r_data;
    assign o_riscv_address   = r_addr;
    assign o_wm_enable_write = r_wm_we;
    assign o_bm_enable_write = r_bm_we;

endmodule

// File: tb/tb_conv_param_loader.sv
// Scoreboard bench for conv_param_loader: the driver queues the expected
// write for every accepted beat, a monitor checks each strobe as it appears.
module tb_conv_param_loader;

    localparam int DW     = 32;
    localparam int AB     = 15;
    localparam int NU     = 3;
    localparam int NF     = 6;
    localparam int WMW    = 150;
    localparam int NBEATS = 456;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic          host_valid;
    logic [DW-1:0] host_data;
    logic          start_in;
    logic          conv_ready;

    logic          o_host_ready;
    logic [DW-1:0] o_riscv_data;
    logic [AB-1:0] o_riscv_address;
    logic [NU-1:0] o_wm_enable_write;
    logic          o_bm_enable_write;
    logic          o_start_from_previous;
    logic          o_params_ready;

    typedef struct packed {
        logic [NU-1:0] wm;
        logic          bm;
        logic [AB-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec     = 0;
    int    n_err     = 0;
    int    sfp_count = 0;
    int    obs_idx   = 0;

    conv_param_loader #(
        .DATA_WIDTH        (DW),
        .ADDRESS_BITS      (AB),
        .KERNAL_SIZE       (5),
        .NUMBER_OF_FILTERS (NF),
        .NUMBER_OF_UNITS   (NU),
        .WM_WORDS          (WMW)
    ) dut (
        .i_clk                 (clk),
        .i_reset               (reset),
        .i_cfg_start           (cfg_start),
        .i_host_valid          (host_valid),
        .i_host_data           (host_data),
        .o_host_ready          (o_host_ready),
        .i_start_in            (start_in),
        .i_conv_ready          (conv_ready),
        .o_riscv_data          (o_riscv_data),
        .o_riscv_address       (o_riscv_address),
        .o_wm_enable_write     (o_wm_enable_write),
        .o_bm_enable_write     (o_bm_enable_write),
        .o_start_from_previous (o_start_from_previous),
        .o_params_ready        (o_params_ready)
    );

    always #5 clk = ~clk;

    // Expected write for beat idx of a load whose data words are base+idx.
    function automatic beat_t model(input int idx, input logic [DW-1:0] base);
        beat_t b;
        b = '0;
        if (idx < NU * WMW) begin
            b.wm   = NU'(1) << (idx / WMW);
            b.addr = AB'(idx % WMW);
        end else begin
            b.bm   = 1'b1;
            b.addr = AB'(idx - NU * WMW);
        end
        b.data = base + DW'(idx);
        return b;
    endfunction

    // Hand-written strobe/address values at the memory boundaries.
    function automatic bit directed_beat(input int idx, output logic [NU+AB:0] want);
        directed_beat = 1'b1;
        case (idx)
            0:       want = {3'b001, 1'b0, 15'd0};
            149:     want = {3'b001, 1'b0, 15'd149};
            150:     want = {3'b010, 1'b0, 15'd0};
            299:     want = {3'b010, 1'b0, 15'd149};
            300:     want = {3'b100, 1'b0, 15'd0};
            449:     want = {3'b100, 1'b0, 15'd149};
            450:     want = {3'b000, 1'b1, 15'd0};
            455:     want = {3'b000, 1'b1, 15'd5};
            default: begin
                want          = '0;
                directed_beat = 1'b0;
            end
        endcase
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({o_host_ready, o_wm_enable_write, o_bm_enable_write,
                    o_start_from_previous, o_params_ready, o_riscv_data, o_riscv_address});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", name, act, want);
        end
    endtask

    // Monitor: count start pulses and check every write strobe.
    initial begin
        forever begin
            beat_t           act;
            beat_t           want_b;
            logic [NU+AB:0]  want_d;
            bit              is_dir;
            @(negedge clk);
            if (o_start_from_previous) sfp_count++;
            if (o_wm_enable_write != '0 || o_bm_enable_write) begin
                act.wm   = o_wm_enable_write;
                act.bm   = o_bm_enable_write;
                act.addr = o_riscv_address;
                act.data = o_riscv_data;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_strobe got wm=%b bm=%b addr=%0d data=%h want no strobe",
                             act.wm, act.bm, act.addr, act.data);
                end else begin
                    want_b = exp_q.pop_front();
                    if (act !== want_b) begin
                        n_err++;
                        $display("FAIL beat%0d got wm=%b bm=%b addr=%0d data=%h want wm=%b bm=%b addr=%0d data=%h",
                                 obs_idx, act.wm, act.bm, act.addr, act.data,
                                 want_b.wm, want_b.bm, want_b.addr, want_b.data);
                    end
                end
                is_dir = directed_beat(obs_idx, want_d);
                if (is_dir) begin
                    n_vec++;
                    if ({act.wm, act.bm, act.addr} !== want_d) begin
                        n_err++;
                        $display("FAIL boundary_beat%0d got %h want %h",
                                 obs_idx, {act.wm, act.bm, act.addr}, want_d);
                    end
                end
                obs_idx++;
            end
        end
    end

    // Pulse cfg_start (optionally with start_in) for one cycle and check the response.
    task automatic do_cfg(input bit cr, input bit st, input bit exp_accept);
        cfg_start  = 1'b1;
        conv_ready = cr;
        start_in   = st;
        @(negedge clk);
        if (st) check("forward_start", 64'(o_start_from_previous), 64'd1);
        @(posedge clk);
        #1;
        cfg_start  = 1'b0;
        start_in   = 1'b0;
        conv_ready = 1'b1;
        check("params_ready_after_cfg", 64'(o_params_ready), 64'(!exp_accept));
        check("host_ready_after_cfg", 64'(o_host_ready), 64'(exp_accept));
        if (exp_accept) obs_idx = 0;
    endtask

    // Drive one load; optionally pulse start_in at two beats or reset at abort_at.
    task automatic run_load(input logic [DW-1:0] base, input int bubble_pct,
                            input int start_a, input int start_b,
                            input int abort_at, input bit exp_start);
        int idx;
        int guard;
        int snap;
        bit rdy;
        bit sa;
        bit sb;
        idx   = 0;
        guard = 0;
        sa    = 1'b0;
        sb    = 1'b0;
        snap  = sfp_count;
        while (idx < NBEATS) begin
            if (idx == abort_at) begin
                host_valid = 1'b0;
                reset      = 1'b1;
                @(posedge clk);
                #1;
                check("reset_mid_load_outputs", all_outs(), 64'd0);
                reset = 1'b0;
                check("reset_mid_load_queue", 64'(exp_q.size()), 64'd0);
                @(posedge clk);
                #1;
                check("idle_after_reset", 64'({o_host_ready, o_params_ready}), 64'd0);
                return;
            end
            host_valid = ($urandom_range(0, 99) >= bubble_pct);
            host_data  = base + DW'(idx);
            start_in   = 1'b0;
            if (idx == start_a && !sa) begin start_in = 1'b1; sa = 1'b1; end
            if (idx == start_b && !sb) begin start_in = 1'b1; sb = 1'b1; end
            @(negedge clk);
            rdy = o_host_ready;
            @(posedge clk);
            if (host_valid && rdy) begin
                exp_q.push_back(model(idx, base));
                idx++;
                guard = 0;
            end else begin
                guard++;
                if (guard > 50) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL handshake_timeout beat %0d host_ready got %b want 1", idx, rdy);
                    #1;
                    host_valid = 1'b0;
                    start_in   = 1'b0;
                    return;
                end
            end
            #1;
            host_valid = 1'b0;
            start_in   = 1'b0;
        end
        check("no_start_during_load", 64'(sfp_count - snap), 64'd0);
        @(negedge clk);
        check("flush_params_ready", 64'(o_params_ready), 64'd0);
        check("flush_host_ready", 64'(o_host_ready), 64'd0);
        @(negedge clk);
        check("done_params_ready", 64'(o_params_ready), 64'd1);
        check("done_start_pulse", 64'(o_start_from_previous), 64'(exp_start));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        check("start_pulse_count", 64'(sfp_count - snap), 64'(exp_start));
        check("done_holds", 64'({o_params_ready, o_host_ready}), 64'b10);
    endtask

    initial begin
        reset      = 1'b1;
        cfg_start  = 1'b0;
        host_valid = 1'b0;
        host_data  = '0;
        start_in   = 1'b0;
        conv_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        reset = 1'b0;

        // Host traffic while idle must be refused.
        host_valid = 1'b1;
        host_data  = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        check("idle_host_ready", 64'(o_host_ready), 64'd0);
        host_valid = 1'b0;

        // Full load from IDLE; conv_ready does not matter there.
        do_cfg(1'b0, 1'b0, 1'b1);
        run_load(32'h0000_0000, 0, -1, -1, -1, 1'b0);

        // Reload request while the layer is busy is ignored.
        do_cfg(1'b0, 1'b0, 1'b0);

        // Reload with a coincident start: forwarded, nothing left pending.
        do_cfg(1'b1, 1'b1, 1'b1);
        run_load(32'h0000_1000, 0, -1, -1, -1, 1'b0);

        // Bubbles plus two early starts collapsing into one release.
        do_cfg(1'b1, 1'b0, 1'b1);
        run_load(32'h0000_2000, 30, 10, 300, -1, 1'b1);

        // Reset at beat 200 drops the partial load and its pending start.
        do_cfg(1'b1, 1'b0, 1'b1);
        run_load(32'h0000_3000, 0, 50, -1, 200, 1'b0);
        do_cfg(1'b0, 1'b0, 1'b1);
        run_load(32'h0000_4000, 10, -1, -1, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
